// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and lock-state encoding used by the
// sync generator and the sync receiver.
package vga_timing_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Active level of the sync pulses
    localparam bit H_POL = 1'b0;
    localparam bit V_POL = 1'b0;

    // Consecutive good frames needed before the receiver reports lock
    localparam int LOCK_FRAMES_DEFAULT = 2;

    typedef enum logic [1:0] {
        LOCK_SEARCH  = 2'd0,
        LOCK_ACQUIRE = 2'd1,
        LOCK_LOCKED  = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Polarity-aware trailing-edge detector for one registered sync signal.
// Flags the first inactive sample that follows an active one.
module sync_edge_detect #(
    parameter bit POLARITY = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_s1,
    output logic trailing_edge
);

    logic sync_s2_q;
    logic sync_s2_d;

    // Second sample of the sync level, compared against the first
    always_comb begin
        sync_s2_d = sync_s1;
    end

    // Delay register; resets to the inactive level so reset cannot fake an edge
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_s2_q <= ~POLARITY;
        end else begin
            sync_s2_q <= sync_s2_d;
        end
    end

    assign trailing_edge = (sync_s2_q == POLARITY) && (sync_s1 != POLARITY);

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates from hsync/vsync trailing
// edges, measures line and frame lengths, locks after consecutive nominal
// frames and emits a qualified pixel stream two cycles after the pins.
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int HACTIVE       = H_ACTIVE,
    parameter int VACTIVE       = V_ACTIVE,
    parameter int HBACKPORCH    = H_BACK,
    parameter int VBACKPORCH    = V_BACK,
    parameter int HTOTAL        = H_TOTAL,
    parameter int VTOTAL        = V_TOTAL,
    parameter bit HSYNCPOLARITY = H_POL,
    parameter bit VSYNCPOLARITY = V_POL,
    parameter int LOCK_FRAMES   = LOCK_FRAMES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [2:0]  rin,
    input  logic [2:0]  gin,
    input  logic [1:0]  bin,
    output logic        pix_valid,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic [2:0]  rout,
    output logic [2:0]  gout,
    output logic [1:0]  bout,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] hmeas,
    output logic [9:0]  vmeas
);

    localparam logic [10:0] HCNT_MAX   = 11'h7FF;
    localparam logic [9:0]  VCNT_MAX   = 10'h3FF;
    localparam logic [10:0] HTOTAL_C   = 11'(HTOTAL);
    localparam logic [10:0] HTIMEOUT_C = 11'(2 * HTOTAL);
    localparam logic [10:0] HACT_LO    = 11'(HBACKPORCH);
    localparam logic [10:0] HACT_HI    = 11'(HBACKPORCH + HACTIVE);
    localparam logic [9:0]  VACT_LO    = 10'(VBACKPORCH);
    localparam logic [9:0]  VACT_HI    = 10'(VBACKPORCH + VACTIVE);
    localparam logic [9:0]  VTOTAL_C   = 10'(VTOTAL);
    localparam logic [7:0]  LOCK_C     = 8'(LOCK_FRAMES);

    // Input stage (S1)
    logic       hs_s1_q;
    logic       vs_s1_q;
    logic [7:0] rgb_s1_q;

    // Edge strobes
    logic hte;
    logic vte;

    // Counters and measurements
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [10:0] hmeas_q, hmeas_d;
    logic [9:0]  vmeas_q, vmeas_d;
    logic        vpend_q, vpend_d;
    logic        line_err_q, line_err_d;

    // Derived per-cycle values
    logic [10:0] h_cur;
    logic [9:0]  vcnt_inc;
    logic        period_bad;
    logic        vpend_now;
    logic        frame_check;
    logic        frame_good;
    logic        timeout;

    // Lock FSM
    lock_state_e state_q, state_d;
    logic [7:0]  good_cnt_q, good_cnt_d;

    // Output register
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  xpos_q, xpos_d;
    logic [9:0]  ypos_q, ypos_d;
    logic [7:0]  rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d;
    logic [10:0] x_full;
    logic [9:0]  y_full;
    logic        pix_ok;

    // Register every pin once; syncs reset to their inactive level
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1_q  <= ~HSYNCPOLARITY;
            vs_s1_q  <= ~VSYNCPOLARITY;
            rgb_s1_q <= '0;
        end else begin
            hs_s1_q  <= hs_in;
            vs_s1_q  <= vs_in;
            rgb_s1_q <= {rin, gin, bin};
        end
    end

    sync_edge_detect #(.POLARITY(HSYNCPOLARITY)) u_hs_edge (
        .clk           (clk),
        .rst           (rst),
        .sync_s1       (hs_s1_q),
        .trailing_edge (hte)
    );

    sync_edge_detect #(.POLARITY(VSYNCPOLARITY)) u_vs_edge (
        .clk           (clk),
        .rst           (rst),
        .sync_s1       (vs_s1_q),
        .trailing_edge (vte)
    );

    // Position counters, measurements and the per-frame error flag.
    // Line errors accumulate over a whole frame and are consumed by the frame
    // check, which is the HTE that acts on a pending vsync edge.
    // NOTE: every variable assigned in an always_comb gets a value on every
    // path (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        h_cur       = hte ? 11'd0 : hcnt_q;
        hcnt_d      = (h_cur == HCNT_MAX) ? h_cur : h_cur + 11'd1;
        period_bad  = hte && (hcnt_q != HTOTAL_C);
        hmeas_d     = hte ? hcnt_q : hmeas_q;
        vpend_now   = vpend_q || vte;
        frame_check = hte && vpend_now;
        vcnt_inc    = vcnt_q + 10'd1;

        vcnt_d     = vcnt_q;
        vmeas_d    = vmeas_q;
        vpend_d    = vpend_now;
        line_err_d = line_err_q || period_bad;

        if (frame_check) begin
            vcnt_d     = '0;
            vmeas_d    = vcnt_inc;
            vpend_d    = 1'b0;
            line_err_d = 1'b0;
        end else if (hte) begin
            vcnt_d = (vcnt_q == VCNT_MAX) ? vcnt_q : vcnt_inc;
        end

        frame_good = !(line_err_q || period_bad) && (vcnt_inc == VTOTAL_C);
        timeout    = (h_cur >= HTIMEOUT_C);
    end

    // Lock state machine: advances on frame checks, falls back on hsync loss
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;

        if (timeout) begin
            state_d    = LOCK_SEARCH;
            good_cnt_d = '0;
        end else if (frame_check) begin
            unique case (state_q)
                LOCK_SEARCH: begin
                    state_d    = LOCK_ACQUIRE;
                    good_cnt_d = '0;
                end
                LOCK_ACQUIRE: begin
                    if (frame_good) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        if (good_cnt_q + 8'd1 >= LOCK_C) begin
                            state_d = LOCK_LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                LOCK_LOCKED: begin
                    if (!frame_good) begin
                        state_d    = LOCK_ACQUIRE;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = LOCK_SEARCH;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    // Qualify the S1 pixel: inside the active window and locked
    always_comb begin
        x_full        = h_cur - HACT_LO;
        y_full        = vcnt_q - VACT_LO;
        pix_ok        = (h_cur >= HACT_LO) && (h_cur < HACT_HI) &&
                        (vcnt_q >= VACT_LO) && (vcnt_q < VACT_HI) &&
                        (state_q == LOCK_LOCKED);
        pix_valid_d   = pix_ok;
        xpos_d        = pix_ok ? x_full[9:0] : 10'd0;
        ypos_d        = pix_ok ? y_full : 10'd0;
        rgb_d         = pix_ok ? rgb_s1_q : 8'd0;
        frame_start_d = pix_ok && (x_full == 11'd0) && (y_full == 10'd0);
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hmeas_q       <= '0;
            vmeas_q       <= '0;
            vpend_q       <= 1'b0;
            line_err_q    <= 1'b0;
            state_q       <= LOCK_SEARCH;
            good_cnt_q    <= '0;
            pix_valid_q   <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hmeas_q       <= hmeas_d;
            vmeas_q       <= vmeas_d;
            vpend_q       <= vpend_d;
            line_err_q    <= line_err_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            pix_valid_q   <= pix_valid_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign rout        = rgb_q[7:5];
    assign gout        = rgb_q[4:2];
    assign bout        = rgb_q[1:0];
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LOCK_LOCKED);
    assign hmeas       = hmeas_q;
    assign vmeas       = vmeas_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Testbench for vga_sync_receiver using scaled-down timing. Two receivers see
// the same stimulus, one with active-low and one with active-high syncs.
module tb_vga_sync_receiver;

    localparam int HS   = 4;
    localparam int HBP  = 6;
    localparam int HACT = 16;
    localparam int HFP  = 6;
    localparam int HTOT = HS + HBP + HACT + HFP;
    localparam int VS   = 2;
    localparam int VBP  = 3;
    localparam int VACT = 8;
    localparam int VFP  = 2;
    localparam int VTOT = VS + VBP + VACT + VFP;
    localparam int LOCKN = 2;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs_act = 1'b0;
    logic vs_act = 1'b0;
    logic [2:0] rin = '0;
    logic [2:0] gin = '0;
    logic [1:0] bin = '0;
    logic hs_pin_n, vs_pin_n;

    logic        pv_n, fs_n, lk_n, pv_p, fs_p, lk_p;
    logic [9:0]  x_n, y_n, vm_n, x_p, y_p, vm_p;
    logic [2:0]  r_n, g_n, r_p, g_p;
    logic [1:0]  b_n, b_p;
    logic [10:0] hm_n, hm_p;

    exp_t q_n[$];
    exp_t q_p[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b1;

    // Event-level lock model: a streak of good frame checks since acquisition
    bit model_search = 1'b1;
    bit clean        = 1'b0;
    int streak       = 0;
    bit lock_exp     = 1'b0;

    assign hs_pin_n = ~hs_act;
    assign vs_pin_n = ~vs_act;

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .HACTIVE(HACT), .VACTIVE(VACT), .HBACKPORCH(HBP), .VBACKPORCH(VBP),
        .HTOTAL(HTOT), .VTOTAL(VTOT), .HSYNCPOLARITY(1'b0), .VSYNCPOLARITY(1'b0),
        .LOCK_FRAMES(LOCKN)
    ) dut_n (
        .clk(clk), .rst(rst), .hs_in(hs_pin_n), .vs_in(vs_pin_n),
        .rin(rin), .gin(gin), .bin(bin),
        .pix_valid(pv_n), .xpos(x_n), .ypos(y_n), .rout(r_n), .gout(g_n), .bout(b_n),
        .frame_start(fs_n), .locked(lk_n), .hmeas(hm_n), .vmeas(vm_n)
    );

    vga_sync_receiver #(
        .HACTIVE(HACT), .VACTIVE(VACT), .HBACKPORCH(HBP), .VBACKPORCH(VBP),
        .HTOTAL(HTOT), .VTOTAL(VTOT), .HSYNCPOLARITY(1'b1), .VSYNCPOLARITY(1'b1),
        .LOCK_FRAMES(LOCKN)
    ) dut_p (
        .clk(clk), .rst(rst), .hs_in(hs_act), .vs_in(vs_act),
        .rin(rin), .gin(gin), .bin(bin),
        .pix_valid(pv_p), .xpos(x_p), .ypos(y_p), .rout(r_p), .gout(g_p), .bout(b_p),
        .frame_start(fs_p), .locked(lk_p), .hmeas(hm_p), .vmeas(vm_p)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare one receiver's output against the head of its scoreboard queue
    task automatic mon(input int id, input logic pv, input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] rgb, input logic fs);
        exp_t  e;
        bit    have;
        logic  fs_e;
        string tag;
        have = 1'b0;
        e    = '0;
        tag  = (id == 0) ? "neg" : "pos";
        if (pv === 1'b1) begin
            if (id == 0 && q_n.size() > 0) begin
                e = q_n.pop_front();
                have = 1'b1;
            end else if (id == 1 && q_p.size() > 0) begin
                e = q_p.pop_front();
                have = 1'b1;
            end
            if (!have) begin
                check({tag, "_unexpected_pixel"}, 64'(pv), 64'(0));
            end else begin
                fs_e = (e.x == 10'd0) && (e.y == 10'd0);
                check({tag, "_pixel_x_y_rgb_fs"}, 64'({x, y, rgb, fs}), 64'({e.x, e.y, e.rgb, fs_e}));
            end
        end else begin
            check({tag, "_idle_rgb_fs_pv"}, 64'({rgb, fs, pv}), 64'(0));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, pv_n, x_n, y_n, {r_n, g_n, b_n}, fs_n);
            mon(1, pv_p, x_p, y_p, {r_p, g_p, b_p}, fs_p);
        end
    end

    // Drive one pixel clock of stimulus; push the expected pixel if qualified
    task automatic drive_cycle(input bit h_a, input bit v_a, input logic [7:0] rgb,
                               input bit push, input int x, input int y);
        exp_t e;
        hs_act = h_a;
        vs_act = v_a;
        {rin, gin, bin} = rgb;
        if (push) begin
            e.x   = 10'(x);
            e.y   = 10'(y);
            e.rgb = rgb;
            q_n.push_back(e);
            q_p.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_neg"}, 64'({pv_n, x_n, y_n, r_n, g_n, b_n, fs_n, lk_n, hm_n, vm_n}), 64'(0));
        check({name, "_pos"}, 64'({pv_p, x_p, y_p, r_p, g_p, b_p, fs_p, lk_p, hm_p, vm_p}), 64'(0));
    endtask

    // One frame check event as seen by the lock rules
    task automatic model_frame_check();
        if (model_search) begin
            model_search = 1'b0;
            streak = 0;
        end else if (clean) begin
            streak++;
        end else begin
            streak = 0;
        end
        clean    = 1'b1;
        lock_exp = !model_search && (streak >= LOCKN);
    endtask

    task automatic reset_pulse();
        hs_act = 1'b0;
        vs_act = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset_midframe_outputs");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        model_search = 1'b1;
        streak       = 0;
        lock_exp     = 1'b0;
    endtask

    // One frame starting with the vsync pulse; the check happens in line VS
    task automatic gen_frame(input int bad_line, input int rst_line);
        int         ax, ay;
        bit         act;
        logic [7:0] pix, seed;
        seed = 8'($urandom);
        model_frame_check();
        if (bad_line >= 0) clean = 1'b0;
        for (int l = 0; l < VTOT; l++) begin
            if (l == VS + 1) begin
                check("locked_neg", 64'(lk_n), 64'(lock_exp));
                check("locked_pos", 64'(lk_p), 64'(lock_exp));
                if (lock_exp) begin
                    check("hmeas_neg", 64'(hm_n), 64'(HTOT));
                    check("vmeas_neg", 64'(vm_n), 64'(VTOT));
                    check("hmeas_pos", 64'(hm_p), 64'(HTOT));
                    check("vmeas_pos", 64'(vm_p), 64'(VTOT));
                end
            end
            for (int c = 0; c < HTOT + ((l == bad_line) ? 1 : 0); c++) begin
                if (l == rst_line && c == HTOT - 3) begin
                    reset_pulse();
                    break;
                end
                ax  = c - HS - HBP;
                ay  = l - VS - VBP;
                act = (ax >= 0) && (ax < HACT) && (ay >= 0) && (ay < VACT);
                pix = act ? (8'(ax ^ ay) ^ seed) : 8'($urandom);
                drive_cycle(c < HS, l < VS, pix, act && lock_exp, ax, ay);
            end
        end
        check("queue_drained_neg", 64'(q_n.size()), 64'(0));
        check("queue_drained_pos", 64'(q_p.size()), 64'(0));
    endtask

    task automatic loss_of_sync(input int n);
        model_search = 1'b1;
        streak       = 0;
        lock_exp     = 1'b0;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 8'($urandom), 1'b0, 0, 0);
        check("loss_locked_neg", 64'(lk_n), 64'(0));
        check("loss_locked_pos", 64'(lk_p), 64'(0));
    endtask

    initial begin
        int bl;
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst = 1'b0;

        // Nominal lock: locked from the third frame check on
        for (int f = 0; f < 5; f++) gen_frame(-1, -1);

        // One long line while locked, then recovery
        gen_frame(int'($urandom_range(VS + 1, VTOT - 1)), -1);
        for (int f = 0; f < 4; f++) gen_frame(-1, -1);

        // hsync lost long enough to time out
        loss_of_sync(1700);
        for (int f = 0; f < 4; f++) gen_frame(-1, -1);

        // Reset in the middle of a locked frame
        gen_frame(-1, VS + VBP + VACT / 2);
        for (int f = 0; f < 4; f++) gen_frame(-1, -1);

        // Random mix of nominal frames and frames with a long line
        for (int f = 0; f < 8; f++) begin
            bl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(VS + 1, VTOT - 1)) : -1;
            gen_frame(bl, -1);
        end

        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
